fetch_sequencer: RTL

Sequences the fetch-stage program counter against the one-cycle-latency instruction SRAM. It chooses the next PC each cycle from sequential increment, hold (stall) or redirect (branch/jump from EX). It tags the instruction word returning from SRAM with its PC and a valid bit, and kills wrong-path returns after a redirect. It sits between the hazard/branch logic and the IF/ID pipeline register, and owns the PC register.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pc_next_mux.sv | 27 ++
 rtl/fetch_sequencer.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        KILL
    } fetch_state_e;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC priority select: redirect, then stall, then increment
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [PC_WIDTH-1:0] pc_next_o,
    output logic                misalign_o
);

    always_comb begin
        pc_next_o = pc_i + PC_WIDTH'(INSTR_BYTES);
        if (redirect_i) begin
            // Misaligned targets are still fetched, from the enclosing word.
            pc_next_o = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end
    end

    assign misalign_o = redirect_i && (redirect_pc_i[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC register, SRAM return tagging and wrong-path kill
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                im_cs_o,
    output logic [PC_WIDTH-1:0] if_pc_o,
    output logic                if_valid_o,
    output logic                flush_o,
    output logic                misalign_o,
    output logic [31:0]         fetch_cnt_o
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                if_valid;

    pc_next_mux #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc_next_mux (
        .pc_i         (pc_q),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .pc_next_o    (pc_d),
        .misalign_o   (misalign_o)
    );

    always_comb begin
        state_d = RUN;
        if (redirect_i) begin
            state_d = KILL;
        end
        // Only a word fetched in RUN is on-path; a redirect now makes it stale too.
        if_valid = (state_q == RUN) && !redirect_i;
        if_pc_d  = (redirect_i || !stall_i) ? pc_q : if_pc_q;
        cnt_d    = cnt_q + 32'(if_valid && !stall_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            if_pc_q <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_pc_q <= if_pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign im_cs_o     = 1'b1;
    assign if_pc_o     = if_pc_q;
    assign if_valid_o  = if_valid;
    assign flush_o     = redirect_i;
    assign fetch_cnt_o = cnt_q;

endmodule
